routing_distributor: RTL and testbench

ROUTING_DISTRIBUTOR -- requirements
Module: routing_distributor

---
 rtl/routing_distributor_pkg.sv | 13 +
 rtl/routing_distributor_lane_decoder.sv | 22 ++
 rtl/routing_distributor.sv | 111 +++++++++++
 tb/tb_routing_distributor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/routing_distributor_pkg.sv
// Shared fabric definitions for the routing distributor: default lane width,
// holding-register FSM encoding and drop counter width.
package routing_distributor_pkg;

   localparam int unsigned DefDataWidth   = 32;
   localparam int unsigned DropCountWidth = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } distState_e;

endpackage

// File: rtl/routing_distributor_lane_decoder.sv
// Purely combinational lane decode: select value to one-hot lane vector plus
// an out-of-range flag.
module lane_decoder #(
   parameter int unsigned NUM_OUTPUTS = 8,
   parameter int unsigned SEL_WIDTH   = 4
) (
   input  logic [SEL_WIDTH-1:0]   sel,
   output logic [NUM_OUTPUTS-1:0] laneOneHot_c,
   output logic                   selInvalid_c
);

   localparam logic [SEL_WIDTH-1:0] NumOutSel = SEL_WIDTH'(NUM_OUTPUTS);

   always_comb begin
      laneOneHot_c = '0;
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
         laneOneHot_c[k] = (sel == SEL_WIDTH'(k));
      end
      selInvalid_c = (sel >= NumOutSel);
   end

endmodule

// File: rtl/routing_distributor.sv
// One-word holding register that forwards each accepted input word to the
// configured output lane; words arriving under an invalid select are counted and dropped.
module routing_distributor
   import routing_distributor_pkg::*;
#(
   parameter int unsigned NUM_OUTPUTS       = 8,
   parameter int unsigned NUM_OUTPUTS_LOG_2 = 3,
   parameter int unsigned DATA_WIDTH        = DefDataWidth
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cfg_we,
   input  logic [NUM_OUTPUTS_LOG_2:0]        cfg_select,
   output logic                              cfg_ready,
   input  logic                              in_valid,
   input  logic [DATA_WIDTH-1:0]             in_data,
   output logic                              in_ready,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUTPUTS-1:0]            out_valid,
   input  logic [NUM_OUTPUTS-1:0]            out_ready,
   output logic                              config_invalid,
   output logic [DropCountWidth-1:0]         drop_count
);

   localparam int unsigned SelW = NUM_OUTPUTS_LOG_2 + 1;

   distState_e                stateQ;
   distState_e                stateD;
   logic [SelW-1:0]           sel_q;
   logic [SelW-1:0]           selD;
   logic [NUM_OUTPUTS-1:0]    laneOneHotQ;
   logic [NUM_OUTPUTS-1:0]    laneOneHot_c;
   logic                      configInvalidQ;
   logic                      selInvalid_c;
   logic [DATA_WIDTH-1:0]     hold_q;
   logic [DropCountWidth-1:0] dropQ;
   logic                      cfgWrite_c;
   logic                      drain_c;
   logic                      accept_c;
   logic                      loadHold_c;

   assign cfg_ready  = (stateQ == EMPTY);
   assign cfgWrite_c = cfg_we & cfg_ready;
   assign selD       = cfgWrite_c ? cfg_select : sel_q;

   // Decode the next select so lane mask and invalid flag update with sel_q.
   lane_decoder #(
      .NUM_OUTPUTS (NUM_OUTPUTS),
      .SEL_WIDTH   (SelW)
   ) u_lane_decoder (
      .sel          (selD),
      .laneOneHot_c (laneOneHot_c),
      .selInvalid_c (selInvalid_c)
   );

   assign drain_c    = |(out_ready & laneOneHotQ);
   assign in_ready   = configInvalidQ | (stateQ == EMPTY) | drain_c;
   assign accept_c   = in_valid & in_ready;
   assign loadHold_c = accept_c & ~configInvalidQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= EMPTY;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         EMPTY: if (loadHold_c) stateD = FULL;
         FULL:  if (drain_c && !loadHold_c) stateD = EMPTY;
      endcase
   end

   // Select, decoded lane, holding word and saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q          <= '0;
         laneOneHotQ    <= NUM_OUTPUTS'(1);
         configInvalidQ <= 1'b0;
         hold_q         <= '0;
         dropQ          <= '0;
      end else begin
         sel_q          <= selD;
         laneOneHotQ    <= laneOneHot_c;
         configInvalidQ <= selInvalid_c;
         if (loadHold_c) begin
            hold_q <= in_data;
         end
         if (accept_c && configInvalidQ && (dropQ != '1)) begin
            dropQ <= dropQ + DropCountWidth'(1);
         end
      end
   end

   always_comb begin
      out_valid = (stateQ == FULL) ? laneOneHotQ : '0;
      out_data  = '0;
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
         if (out_valid[k]) begin
            out_data[k*DATA_WIDTH +: DATA_WIDTH] = hold_q;
         end
      end
   end

   assign config_invalid = configInvalidQ;
   assign drop_count     = dropQ;

endmodule

// File: tb/tb_routing_distributor.sv
// Scoreboard bench for routing_distributor: directed stimulus queues expected
// lane/word pairs, a negedge monitor pops them on every output handshake.
module tb_routing_distributor;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cfg_we;
   logic [3:0]   cfg_select;
   logic         cfg_ready;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_ready;
   logic [255:0] out_data;
   logic [7:0]   out_valid;
   logic [7:0]   out_ready;
   logic         config_invalid;
   logic [7:0]   drop_count;

   typedef struct {
      int          lane;
      logic [31:0] data;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   passes = 0;
   int   modelSel = 0;
   bit   modelInvalid = 1'b0;
   bit   sawValid = 1'b0;

   routing_distributor dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_we         (cfg_we),
      .cfg_select     (cfg_select),
      .cfg_ready      (cfg_ready),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .config_invalid (config_invalid),
      .drop_count     (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [255:0] laneVec(input int lane, input logic [31:0] d);
      logic [255:0] v;
      v = '0;
      v[lane*32 +: 32] = d;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int s);
      cfg_we = 1'b1;
      cfg_select = 4'(s);
      tick();
      cfg_we = 1'b0;
      modelSel = s;
      modelInvalid = (s >= 8);
   endtask

   // Present one word, wait (bounded) for in_ready, record the expectation.
   task automatic push(input logic [31:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data = d;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("push_timeout", 256'(in_ready), 256'(1));
      else if (!modelInvalid) expQ.push_back('{modelSel, d});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int k = 0; k < 8; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               if (expQ.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_word: lane %0d data %0h with empty scoreboard",
                           k, out_data[k*32 +: 32]);
               end else begin
                  e = expQ.pop_front();
                  check("out_lane", 256'(k), 256'(e.lane));
                  check("out_data", 256'(out_data[k*32 +: 32]), 256'(e.data));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      cfg_we = 1'b0;
      cfg_select = '0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(out_valid), 256'(0));
      check("rst_out_data", out_data, 256'(0));
      check("rst_config_invalid", 256'(config_invalid), 256'(0));
      check("rst_drop_count", 256'(drop_count), 256'(0));
      check("rst_cfg_ready", 256'(cfg_ready), 256'(1));
      check("rst_in_ready", 256'(in_ready), 256'(1));
      rst_n = 1'b1;
      tick();

      // Single word to lane 3, drained immediately.
      cfg(3);
      out_ready = 8'h08;
      push(32'hDEADBEEF);
      check("l3_out_valid", 256'(out_valid), 256'(8'h08));
      check("l3_out_data", out_data, laneVec(3, 32'hDEADBEEF));
      tick();
      check("l3_empty_after", 256'(out_valid), 256'(0));
      check("l3_cfg_ready", 256'(cfg_ready), 256'(1));

      // Backpressure on lane 5, then drain and accept in the same cycle.
      cfg(5);
      out_ready = 8'h00;
      push(32'h1);
      tick();
      tick();
      check("bp_out_valid", 256'(out_valid), 256'(8'h20));
      check("bp_in_ready", 256'(in_ready), 256'(0));
      check("bp_hold_stable", out_data, laneVec(5, 32'h1));
      out_ready = 8'h20;
      push(32'h2);
      check("nobubble_valid", 256'(out_valid), 256'(8'h20));
      check("nobubble_data", out_data, laneVec(5, 32'h2));
      tick();
      out_ready = 8'h00;
      check("bp_empty_after", 256'(out_valid), 256'(0));

      // Config write while FULL is ignored, then lands once EMPTY.
      cfg(2);
      push(32'hAA);
      cfg_we = 1'b1;
      cfg_select = 4'd6;
      #1;
      check("full_cfg_ready", 256'(cfg_ready), 256'(0));
      tick();
      check("full_sel_held", 256'(out_valid), 256'(8'h04));
      out_ready = 8'h04;
      tick();
      tick();
      cfg_we = 1'b0;
      modelSel = 6;
      check("deferred_empty", 256'(out_valid), 256'(0));
      out_ready = 8'h40;
      push(32'hBB);
      check("deferred_lane", 256'(out_valid), 256'(8'h40));
      tick();
      out_ready = 8'h00;

      // Invalid select: words dropped, counter saturates.
      cfg(9);
      check("inv_flag", 256'(config_invalid), 256'(1));
      check("inv_in_ready", 256'(in_ready), 256'(1));
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_data = 32'(i);
         if (i == 200) check("drop_200", 256'(drop_count), 256'(200));
         tick();
         if (out_valid != 8'h00) sawValid = 1'b1;
      end
      in_valid = 1'b0;
      check("drop_saturated", 256'(drop_count), 256'(255));
      check("inv_no_valid", 256'(sawValid), 256'(0));

      // Reset pulsed mid-cycle while holding a word for lane 7.
      cfg(7);
      check("recover_flag", 256'(config_invalid), 256'(0));
      push(32'h77);
      check("l7_out_valid", 256'(out_valid), 256'(8'h80));
      #2;
      rst_n = 1'b0;
      #1;
      expQ.delete();
      check("midrst_out_valid", 256'(out_valid), 256'(0));
      check("midrst_out_data", out_data, 256'(0));
      check("midrst_drop", 256'(drop_count), 256'(0));
      check("midrst_cfg_inv", 256'(config_invalid), 256'(0));
      rst_n = 1'b1;
      modelSel = 0;
      modelInvalid = 1'b0;
      tick();
      check("post_rst_cfg_ready", 256'(cfg_ready), 256'(1));
      check("post_rst_in_ready", 256'(in_ready), 256'(1));
      out_ready = 8'h01;
      push(32'h55);
      check("post_rst_sel0", 256'(out_valid), 256'(8'h01));
      tick();

      // Back-to-back stream on lane 0.
      out_ready = 8'hFF;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 32'h1000 + 32'(i);
         @(negedge clk);
         check("stream_in_ready", 256'(in_ready), 256'(1));
         expQ.push_back('{0, 32'h1000 + 32'(i)});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("scoreboard_drained", 256'(expQ.size()), 256'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
